iq_wakeup_rdy: RTL and testbench
================================

Name: iq_wakeup_rdy

Overview:
- Receiving end of the tag-broadcast (RSR) wakeup bus. Sits in the issue queue next to the select logic.
- Holds per-entry source tags and ready bits for IQ_SIZE entries, and compares them against the three broadcast tags every cycle.
- Produces a per-entry request vector for select.
- Tracks branch masks so that a mispredict squashes dependent entries, and a correctly predicted branch clears its mask bit.

Parameters:
- IQ_SIZE, 16, number of issue-queue entries
- IQ_SIZE_LOG, 4, log2(IQ_SIZE)
- SIZE_PHYSICAL_LOG, 7, physical register tag width
- CHECKPOINTS, 8, branch checkpoint count (branch mask width)
- CHECKPOINTS_LOG, 3, log2(CHECKPOINTS)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- dispValid_i  in  1  write one entry this cycle
- dispIdx_i  in  IQ_SIZE_LOG  entry being written
- dispSrc1Tag_i / dispSrc2Tag_i  in  SIZE_PHYSICAL_LOG  source tags
- dispSrc1Rdy_i / dispSrc2Rdy_i  in  1  source ready at rename
- dispBranchMask_i  in  CHECKPOINTS  branch dependence mask
- rsr0TagValid_i, rsr1TagValid_i, rsr2TagValid_i  in  1  broadcast valids
- rsr0Tag_i, rsr1Tag_i, rsr2Tag_i  in  SIZE_PHYSICAL_LOG  broadcast tags
- freeValid_i  in  1  entry granted and leaving the queue
- freeIdx_i  in  IQ_SIZE_LOG  entry to free
- ctrlVerified_i  in  1  branch resolved this cycle
- ctrlMispredict_i  in  1  resolved branch mispredicted
- ctrlSMTid_i  in  CHECKPOINTS_LOG  checkpoint id of resolved branch
- requestVector_o  out  IQ_SIZE  entry valid and both sources ready
- validVector_o  out  IQ_SIZE  entry occupied
- squashVector_o  out  IQ_SIZE  one-cycle pulse: entries squashed at last edge
- validCount_o  out  IQ_SIZE_LOG+1  number of occupied entries

Behaviour:
- Reset (synchronous, high at a rising edge):
  - all valid, ready, tag and mask state goes to 0;
  - requestVector_o, validVector_o, squashVector_o and validCount_o all read 0 the cycle after.
  - Reset mid-operation drops every entry. No squash pulse is generated.
- Per-entry state: valid, src1Tag, src1Rdy, src2Tag, src2Rdy, branchMask.
- Match definition: source x of entry e matches when any rsrK is valid and rsrKTag_i equals srcxTag. Tags are compared only when the corresponding valid is high; tag value 0 is not special.
- Wakeup latency:
  - a broadcast in cycle N sets the ready bit at the edge ending cycle N;
  - requestVector_o reflects it in cycle N+1.
  - The ready bit stays set until the entry is freed, squashed or rewritten.
- requestVector_o[e] = valid & src1Rdy & src2Rdy, decoded combinationally from registers. There is no combinational path from rsr*_i to the outputs.
- Dispatch bypass: a dispatched source is written ready when dispSrcxRdy_i is high OR the source tag matches a broadcast in the same cycle. This prevents a lost wakeup.
- Free: freeValid_i clears valid[freeIdx_i] at the edge. Freeing an invalid entry is a no-op.
- Branch resolve when ctrlVerified_i is high (b = ctrlSMTid_i):
  - Mispredict:
    - every valid entry with branchMask[b]=1 is invalidated;
    - squashVector_o pulses for those entries in the next cycle;
    - a dispatch in the same cycle with dispBranchMask_i[b]=1 is not written.
  - Correct prediction: bit b is cleared in every entry mask, including the mask being dispatched that cycle.
- Simultaneous events:
  - dispatch and free to the same index in one cycle: dispatch wins and the entry is valid.
  - Free and squash of the same entry: entry invalid, squash bit set.
  - Dispatch to an already-valid index overwrites it. This is a protocol error, and the bench flags it with an assertion.
- validCount_o is the registered population count of the valid bits after update. Range is 0..IQ_SIZE; at full it reads IQ_SIZE (e.g. 16).
- Wakeup on invalid entries still updates their ready bits. Those bits are don't-care and are masked by valid.

Decomposition:
- Shared package: IQ_SIZE, IQ_SIZE_LOG, SIZE_PHYSICAL_LOG, CHECKPOINTS, CHECKPOINTS_LOG, and the number of broadcast ports (3).
- Sub-module iq_wakeup_cam: a single-source, 3-port tag comparator returning a match bit. Instantiated 2×IQ_SIZE times, plus twice on the dispatch path.

Test Plan:
- Reset: assert reset with 5 entries valid → next cycle validVector_o=0, requestVector_o=0, validCount_o=0, squashVector_o=0.
- Wakeup:
  - dispatch idx 3 with src1=0x12 (not ready) and src2=0x05 (ready);
  - 2 cycles later rsr1Tag_i=0x12 valid;
  - expect requestVector_o[3]=1 exactly one cycle later, and 0 before.
- Bypass: dispatch idx 7 with src1=0x20 not ready while rsr0Tag_i=0x20 valid in the same cycle → requestVector_o[7]=1 the next cycle.
- Mispredict:
  - entries 1,2 have mask 8'b0000_0100 and entry 4 has 0;
  - ctrlVerified=1, ctrlMispredict=1, SMTid=2;
  - expect validVector_o bits 1,2 cleared, squashVector_o=0x0006 for one cycle, entry 4 kept, validCount_o decremented by 2.
- Correct branch: same setup with ctrlMispredict=0 → no squash and masks clear bit 2. A later mispredict on id 2 squashes nothing.
- Full/collision:
  - fill all 16 entries → validCount_o=16;
  - then free idx 5 and dispatch idx 5 in the same cycle → validVector_o[5]=1 and validCount_o=16.

Source files
------------

// File: rtl/iq_wakeup_rdy_pkg.sv
// Shared sizes, entry layout and helpers for the issue-queue wakeup/ready block.
package iq_wakeup_rdy_pkg;

    localparam int unsigned IQ_SIZE           = 16;
    localparam int unsigned IQ_SIZE_LOG       = 4;
    localparam int unsigned SIZE_PHYSICAL_LOG = 7;
    localparam int unsigned CHECKPOINTS       = 8;
    localparam int unsigned CHECKPOINTS_LOG   = 3;
    localparam int unsigned RSR_PORTS         = 3;
    localparam int unsigned COUNT_W           = IQ_SIZE_LOG + 1;

    typedef logic [SIZE_PHYSICAL_LOG-1:0] physTag_t;
    typedef logic [CHECKPOINTS-1:0]       branchMask_t;

    typedef struct packed {
        logic        valid;
        physTag_t    src1Tag;
        logic        src1Rdy;
        physTag_t    src2Tag;
        logic        src2Rdy;
        branchMask_t branchMask;
    } iqEntry_t;

    // All broadcast ports bundled so a comparator sees them as one payload
    typedef struct packed {
        logic [RSR_PORTS-1:0]                        valid;
        logic [RSR_PORTS-1:0][SIZE_PHYSICAL_LOG-1:0] tag;
    } rsrBus_t;

    function automatic logic [COUNT_W-1:0] popCount(input logic [IQ_SIZE-1:0] vec);
        logic [COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(IQ_SIZE); i++) begin
            n = n + COUNT_W'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/iq_wakeup_rdy_if.sv
// Dispatch, broadcast, free, branch-resolve and select-side signals of the wakeup block.
interface iq_wakeup_rdy_if;
    import iq_wakeup_rdy_pkg::*;

    logic                       dispValid_i;
    logic [IQ_SIZE_LOG-1:0]     dispIdx_i;
    physTag_t                   dispSrc1Tag_i;
    physTag_t                   dispSrc2Tag_i;
    logic                       dispSrc1Rdy_i;
    logic                       dispSrc2Rdy_i;
    branchMask_t                dispBranchMask_i;
    logic                       rsr0TagValid_i;
    logic                       rsr1TagValid_i;
    logic                       rsr2TagValid_i;
    physTag_t                   rsr0Tag_i;
    physTag_t                   rsr1Tag_i;
    physTag_t                   rsr2Tag_i;
    logic                       freeValid_i;
    logic [IQ_SIZE_LOG-1:0]     freeIdx_i;
    logic                       ctrlVerified_i;
    logic                       ctrlMispredict_i;
    logic [CHECKPOINTS_LOG-1:0] ctrlSMTid_i;
    logic [IQ_SIZE-1:0]         requestVector_o;
    logic [IQ_SIZE-1:0]         validVector_o;
    logic [IQ_SIZE-1:0]         squashVector_o;
    logic [COUNT_W-1:0]         validCount_o;

    modport master (
        output dispValid_i, dispIdx_i, dispSrc1Tag_i, dispSrc2Tag_i,
               dispSrc1Rdy_i, dispSrc2Rdy_i, dispBranchMask_i,
               rsr0TagValid_i, rsr1TagValid_i, rsr2TagValid_i,
               rsr0Tag_i, rsr1Tag_i, rsr2Tag_i,
               freeValid_i, freeIdx_i,
               ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i,
        input  requestVector_o, validVector_o, squashVector_o, validCount_o
    );

    modport slave (
        input  dispValid_i, dispIdx_i, dispSrc1Tag_i, dispSrc2Tag_i,
               dispSrc1Rdy_i, dispSrc2Rdy_i, dispBranchMask_i,
               rsr0TagValid_i, rsr1TagValid_i, rsr2TagValid_i,
               rsr0Tag_i, rsr1Tag_i, rsr2Tag_i,
               freeValid_i, freeIdx_i,
               ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i,
        output requestVector_o, validVector_o, squashVector_o, validCount_o
    );

endinterface

// File: rtl/iq_wakeup_cam.sv
// Single-source comparator against every broadcast port; a port only counts while its valid is high.
module iq_wakeup_cam
    import iq_wakeup_rdy_pkg::*;
(
    input  physTag_t srcTag,
    input  rsrBus_t  rsr,
    output logic     match_c
);

    always_comb begin
        match_c = 1'b0;
        for (int k = 0; k < int'(RSR_PORTS); k++) begin
            if (rsr.valid[k] && (rsr.tag[k] == srcTag)) begin
                match_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iq_wakeup_rdy.sv
// Issue-queue wakeup: per-entry source-ready tracking, branch-mask squash/clear and select request vector.
module iq_wakeup_rdy
    import iq_wakeup_rdy_pkg::*;
(
    input logic           clock,
    input logic           reset,
    iq_wakeup_rdy_if.slave bus
);

    rsrBus_t            rsr;
    iqEntry_t           entries     [IQ_SIZE];
    iqEntry_t           entriesNext [IQ_SIZE];
    iqEntry_t           dispEntry;
    logic [IQ_SIZE-1:0] wake1;
    logic [IQ_SIZE-1:0] wake2;
    logic [IQ_SIZE-1:0] squashNext;
    logic [IQ_SIZE-1:0] validNext;
    logic [IQ_SIZE-1:0] validVector;
    logic [IQ_SIZE-1:0] requestVector;
    logic [IQ_SIZE-1:0] squashVector;
    logic [COUNT_W-1:0] validCount;
    logic               dispMatch1;
    logic               dispMatch2;
    logic               mispredict;
    logic               correct;
    logic               dispWrite;
    branchMask_t        clearMask;

    assign rsr.valid = {bus.rsr2TagValid_i, bus.rsr1TagValid_i, bus.rsr0TagValid_i};
    assign rsr.tag   = {bus.rsr2Tag_i, bus.rsr1Tag_i, bus.rsr0Tag_i};

    // Resident-entry comparators plus decode of state into the select-facing vectors
    for (genvar e = 0; e < int'(IQ_SIZE); e++) begin : gEntry
        iq_wakeup_cam uSrc1Cam (.srcTag(entries[e].src1Tag), .rsr(rsr), .match_c(wake1[e]));
        iq_wakeup_cam uSrc2Cam (.srcTag(entries[e].src2Tag), .rsr(rsr), .match_c(wake2[e]));

        assign validVector[e]   = entries[e].valid;
        assign requestVector[e] = entries[e].valid & entries[e].src1Rdy & entries[e].src2Rdy;
        assign validNext[e]     = entriesNext[e].valid;
    end

    // Dispatch-path comparators close the window where a tag broadcasts as its consumer is written
    iq_wakeup_cam uDispSrc1Cam (.srcTag(bus.dispSrc1Tag_i), .rsr(rsr), .match_c(dispMatch1));
    iq_wakeup_cam uDispSrc2Cam (.srcTag(bus.dispSrc2Tag_i), .rsr(rsr), .match_c(dispMatch2));

    assign mispredict = bus.ctrlVerified_i & bus.ctrlMispredict_i;
    assign correct    = bus.ctrlVerified_i & ~bus.ctrlMispredict_i;
    assign clearMask  = correct ? (branchMask_t'(1) << bus.ctrlSMTid_i) : '0;
    assign dispWrite  = bus.dispValid_i & ~(mispredict & bus.dispBranchMask_i[bus.ctrlSMTid_i]);

    always_comb begin
        dispEntry            = '0;
        dispEntry.valid      = 1'b1;
        dispEntry.src1Tag    = bus.dispSrc1Tag_i;
        dispEntry.src1Rdy    = bus.dispSrc1Rdy_i | dispMatch1;
        dispEntry.src2Tag    = bus.dispSrc2Tag_i;
        dispEntry.src2Rdy    = bus.dispSrc2Rdy_i | dispMatch2;
        dispEntry.branchMask = bus.dispBranchMask_i & ~clearMask;
    end

    // Priority per entry: wakeup/mask-clear, then free/squash, then dispatch overwrites all
    always_comb begin
        logic squashHit;
        squashHit  = 1'b0;
        squashNext = '0;
        for (int e = 0; e < int'(IQ_SIZE); e++) begin
            entriesNext[e]            = entries[e];
            entriesNext[e].src1Rdy    = entries[e].src1Rdy | wake1[e];
            entriesNext[e].src2Rdy    = entries[e].src2Rdy | wake2[e];
            entriesNext[e].branchMask = entries[e].branchMask & ~clearMask;
            squashHit = mispredict & entries[e].valid & entries[e].branchMask[bus.ctrlSMTid_i];
            squashNext[e] = squashHit;
            if ((bus.freeValid_i && (bus.freeIdx_i == IQ_SIZE_LOG'(e))) || squashHit) begin
                entriesNext[e].valid = 1'b0;
            end
            if (dispWrite && (bus.dispIdx_i == IQ_SIZE_LOG'(e))) begin
                entriesNext[e] = dispEntry;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < int'(IQ_SIZE); e++) begin
                entries[e] <= '0;
            end
            squashVector <= '0;
            validCount   <= '0;
        end else begin
            for (int e = 0; e < int'(IQ_SIZE); e++) begin
                entries[e] <= entriesNext[e];
            end
            squashVector <= squashNext;
            validCount   <= popCount(validNext);
        end
    end

    assign bus.requestVector_o = requestVector;
    assign bus.validVector_o   = validVector;
    assign bus.squashVector_o  = squashVector;
    assign bus.validCount_o    = validCount;

endmodule

// File: tb/tb_iq_wakeup_rdy.sv
// Self-checking bench for iq_wakeup_rdy: directed vector table, fill/collision sequence, then random traffic against a model.
module tb_iq_wakeup_rdy;
    import iq_wakeup_rdy_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        dv;
        logic [3:0]  di;
        logic [6:0]  t1;
        logic        r1;
        logic [6:0]  t2;
        logic        r2;
        logic [7:0]  dm;
        logic [2:0]  rv;
        logic [6:0]  rt0;
        logic [6:0]  rt1;
        logic [6:0]  rt2;
        logic        fv;
        logic [3:0]  fi;
        logic        cv;
        logic        cm;
        logic [2:0]  cid;
        logic [15:0] eReq;
        logic [15:0] eValid;
        logic [15:0] eSquash;
        logic [4:0]  eCount;
    } vec_t;

    typedef struct packed {
        logic [15:0] req;
        logic [15:0] valid;
        logic [15:0] squash;
        logic [4:0]  count;
        logic [15:0] id;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    iq_wakeup_rdy_if bus ();
    iq_wakeup_rdy dut (.clock(clock), .reset(reset), .bus(bus.slave));

    int   applied     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    vec_t tbl[$];

    // Reference state for the random phase
    logic       mValid [16];
    logic [6:0] mT1    [16];
    logic [6:0] mT2    [16];
    logic       mR1    [16];
    logic       mR2    [16];
    logic [7:0] mMask  [16];

    function automatic vec_t nop();
        vec_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_t rstV();
        vec_t v;
        v = '0;
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic vec_t dsp(input logic [3:0] di, input logic [6:0] t1, input logic r1,
                                 input logic [6:0] t2, input logic r2, input logic [7:0] dm);
        vec_t v;
        v = '0;
        v.dv = 1'b1; v.di = di; v.t1 = t1; v.r1 = r1; v.t2 = t2; v.r2 = r2; v.dm = dm;
        return v;
    endfunction

    function automatic vec_t bc(input vec_t vin, input int k, input logic [6:0] t);
        vec_t v;
        v = vin;
        v.rv[k] = 1'b1;
        if (k == 0) v.rt0 = t;
        else if (k == 1) v.rt1 = t;
        else v.rt2 = t;
        return v;
    endfunction

    function automatic vec_t fr(input vec_t vin, input logic [3:0] idx);
        vec_t v;
        v = vin;
        v.fv = 1'b1; v.fi = idx;
        return v;
    endfunction

    function automatic vec_t br(input vec_t vin, input logic mis, input logic [2:0] id);
        vec_t v;
        v = vin;
        v.cv = 1'b1; v.cm = mis; v.cid = id;
        return v;
    endfunction

    function automatic vec_t withExp(input vec_t vin, input logic [15:0] req, input logic [15:0] valid,
                                     input logic [15:0] squash, input logic [4:0] cnt);
        vec_t v;
        v = vin;
        v.eReq = req; v.eValid = valid; v.eSquash = squash; v.eCount = cnt;
        return v;
    endfunction

    function automatic logic bcast(input vec_t v, input logic [6:0] t);
        return (v.rv[0] && v.rt0 == t) || (v.rv[1] && v.rt1 == t) || (v.rv[2] && v.rt2 == t);
    endfunction

    task automatic modelStep(inout vec_t v);
        logic [15:0] sq;
        logic [4:0]  cnt;
        sq = '0;
        if (v.rst) begin
            for (int i = 0; i < 16; i++) begin
                mValid[i] = 1'b0; mT1[i] = '0; mT2[i] = '0;
                mR1[i] = 1'b0; mR2[i] = 1'b0; mMask[i] = '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (v.cv && v.cm && mValid[i] && mMask[i][v.cid]) sq[i] = 1'b1;
                if (bcast(v, mT1[i])) mR1[i] = 1'b1;
                if (bcast(v, mT2[i])) mR2[i] = 1'b1;
                if (v.cv && !v.cm) mMask[i][v.cid] = 1'b0;
                if ((v.fv && v.fi == 4'(i)) || sq[i]) mValid[i] = 1'b0;
            end
            if (v.dv && !(v.cv && v.cm && v.dm[v.cid])) begin
                mValid[v.di] = 1'b1;
                mT1[v.di]    = v.t1;
                mT2[v.di]    = v.t2;
                mR1[v.di]    = v.r1 || bcast(v, v.t1);
                mR2[v.di]    = v.r2 || bcast(v, v.t2);
                mMask[v.di]  = v.dm;
                if (v.cv && !v.cm) mMask[v.di][v.cid] = 1'b0;
            end
        end
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            v.eValid[i] = mValid[i];
            v.eReq[i]   = mValid[i] && mR1[i] && mR2[i];
            cnt = cnt + 5'(mValid[i]);
        end
        v.eSquash = sq;
        v.eCount  = cnt;
    endtask

    // Drive on the falling edge, queue the expectation, check just after the rising edge
    task automatic applyVec(input vec_t v, input int id);
        exp_t e;
        exp_t got;
        @(negedge clock);
        reset                = v.rst;
        bus.dispValid_i      = v.dv;
        bus.dispIdx_i        = v.di;
        bus.dispSrc1Tag_i    = v.t1;
        bus.dispSrc1Rdy_i    = v.r1;
        bus.dispSrc2Tag_i    = v.t2;
        bus.dispSrc2Rdy_i    = v.r2;
        bus.dispBranchMask_i = v.dm;
        bus.rsr0TagValid_i   = v.rv[0];
        bus.rsr1TagValid_i   = v.rv[1];
        bus.rsr2TagValid_i   = v.rv[2];
        bus.rsr0Tag_i        = v.rt0;
        bus.rsr1Tag_i        = v.rt1;
        bus.rsr2Tag_i        = v.rt2;
        bus.freeValid_i      = v.fv;
        bus.freeIdx_i        = v.fi;
        bus.ctrlVerified_i   = v.cv;
        bus.ctrlMispredict_i = v.cm;
        bus.ctrlSMTid_i      = v.cid;
        #1;
        assert (!(v.dv && !v.rst && bus.validVector_o[v.di] && !(v.fv && v.fi == v.di)))
            else $error("protocol: dispatch to occupied entry %0d in vec%0d", v.di, id);
        e.req = v.eReq; e.valid = v.eValid; e.squash = v.eSquash; e.count = v.eCount; e.id = 16'(id);
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        applied++;
        if (bus.requestVector_o !== got.req || bus.validVector_o !== got.valid ||
            bus.squashVector_o !== got.squash || bus.validCount_o !== got.count) begin
            miscompares++;
            $display("FAIL vec%0d: req=%h want %h, valid=%h want %h, squash=%h want %h, count=%0d want %0d",
                     got.id, bus.requestVector_o, got.req, bus.validVector_o, got.valid,
                     bus.squashVector_o, got.squash, bus.validCount_o, got.count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        v = nop();
        // reset with five entries populated
        tbl.push_back(withExp(rstV(), 16'h0000, 16'h0000, 16'h0000, 5'd0));
        tbl.push_back(withExp(dsp(4'd0, 7'h01, 1'b1, 7'h02, 1'b1, 8'h00), 16'h0001, 16'h0001, 16'h0000, 5'd1));
        tbl.push_back(withExp(dsp(4'd1, 7'h03, 1'b0, 7'h04, 1'b1, 8'h00), 16'h0001, 16'h0003, 16'h0000, 5'd2));
        tbl.push_back(withExp(dsp(4'd2, 7'h05, 1'b1, 7'h06, 1'b1, 8'h00), 16'h0005, 16'h0007, 16'h0000, 5'd3));
        tbl.push_back(withExp(dsp(4'd3, 7'h07, 1'b0, 7'h08, 1'b0, 8'h00), 16'h0005, 16'h000F, 16'h0000, 5'd4));
        tbl.push_back(withExp(dsp(4'd4, 7'h09, 1'b1, 7'h0A, 1'b1, 8'h00), 16'h0015, 16'h001F, 16'h0000, 5'd5));
        tbl.push_back(withExp(rstV(), 16'h0000, 16'h0000, 16'h0000, 5'd0));
        tbl.push_back(withExp(nop(), 16'h0000, 16'h0000, 16'h0000, 5'd0));
        // wakeup latency; an invalid port carrying the tag must not wake
        tbl.push_back(withExp(dsp(4'd3, 7'h12, 1'b0, 7'h05, 1'b1, 8'h00), 16'h0000, 16'h0008, 16'h0000, 5'd1));
        v.rt2 = 7'h12;
        tbl.push_back(withExp(v, 16'h0000, 16'h0008, 16'h0000, 5'd1));
        tbl.push_back(withExp(bc(bc(nop(), 1, 7'h12), 0, 7'h05), 16'h0008, 16'h0008, 16'h0000, 5'd1));
        tbl.push_back(withExp(nop(), 16'h0008, 16'h0008, 16'h0000, 5'd1));
        // dispatch bypass on each source, tag zero included
        tbl.push_back(withExp(bc(dsp(4'd7, 7'h20, 1'b0, 7'h21, 1'b1, 8'h00), 0, 7'h20), 16'h0088, 16'h0088, 16'h0000, 5'd2));
        tbl.push_back(withExp(bc(dsp(4'd8, 7'h30, 1'b1, 7'h00, 1'b0, 8'h00), 2, 7'h00), 16'h0188, 16'h0188, 16'h0000, 5'd3));
        tbl.push_back(withExp(bc(dsp(4'd9, 7'h31, 1'b0, 7'h32, 1'b0, 8'h00), 1, 7'h31), 16'h0188, 16'h0388, 16'h0000, 5'd4));
        tbl.push_back(withExp(bc(nop(), 2, 7'h32), 16'h0388, 16'h0388, 16'h0000, 5'd4));
        // free, then free of an already-invalid entry
        tbl.push_back(withExp(fr(nop(), 4'd3), 16'h0380, 16'h0380, 16'h0000, 5'd3));
        tbl.push_back(withExp(fr(nop(), 4'd3), 16'h0380, 16'h0380, 16'h0000, 5'd3));
        tbl.push_back(withExp(rstV(), 16'h0000, 16'h0000, 16'h0000, 5'd0));
        // mispredict on id 2, with a blocked same-cycle dispatch
        tbl.push_back(withExp(dsp(4'd1, 7'h40, 1'b1, 7'h41, 1'b1, 8'h04), 16'h0002, 16'h0002, 16'h0000, 5'd1));
        tbl.push_back(withExp(dsp(4'd2, 7'h42, 1'b0, 7'h43, 1'b1, 8'h04), 16'h0002, 16'h0006, 16'h0000, 5'd2));
        tbl.push_back(withExp(dsp(4'd4, 7'h44, 1'b1, 7'h45, 1'b1, 8'h00), 16'h0012, 16'h0016, 16'h0000, 5'd3));
        tbl.push_back(withExp(br(dsp(4'd5, 7'h46, 1'b1, 7'h47, 1'b1, 8'h04), 1'b1, 3'd2), 16'h0010, 16'h0010, 16'h0006, 5'd1));
        tbl.push_back(withExp(nop(), 16'h0010, 16'h0010, 16'h0000, 5'd1));
        tbl.push_back(withExp(br(dsp(4'd6, 7'h46, 1'b1, 7'h47, 1'b1, 8'h02), 1'b1, 3'd2), 16'h0050, 16'h0050, 16'h0000, 5'd2));
        tbl.push_back(withExp(dsp(4'd1, 7'h48, 1'b1, 7'h49, 1'b1, 8'h08), 16'h0052, 16'h0052, 16'h0000, 5'd3));
        tbl.push_back(withExp(br(fr(nop(), 4'd1), 1'b1, 3'd3), 16'h0050, 16'h0050, 16'h0002, 5'd2));
        tbl.push_back(withExp(rstV(), 16'h0000, 16'h0000, 16'h0000, 5'd0));
        // correct prediction clears bit 2 everywhere, so a later mispredict squashes nothing
        tbl.push_back(withExp(dsp(4'd1, 7'h50, 1'b1, 7'h51, 1'b1, 8'h04), 16'h0002, 16'h0002, 16'h0000, 5'd1));
        tbl.push_back(withExp(dsp(4'd2, 7'h52, 1'b0, 7'h53, 1'b1, 8'h04), 16'h0002, 16'h0006, 16'h0000, 5'd2));
        tbl.push_back(withExp(dsp(4'd4, 7'h54, 1'b1, 7'h55, 1'b1, 8'h00), 16'h0012, 16'h0016, 16'h0000, 5'd3));
        tbl.push_back(withExp(br(dsp(4'd5, 7'h56, 1'b1, 7'h57, 1'b1, 8'h04), 1'b0, 3'd2), 16'h0032, 16'h0036, 16'h0000, 5'd4));
        tbl.push_back(withExp(br(nop(), 1'b1, 3'd2), 16'h0032, 16'h0036, 16'h0000, 5'd4));
        tbl.push_back(withExp(rstV(), 16'h0000, 16'h0000, 16'h0000, 5'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyVec(tbl[i], i);
        end

        // fill to capacity, then free/dispatch collision and reset over a pending mispredict
        for (int i = 0; i < 16; i++) begin
            logic [15:0] full;
            full = 16'((32'h1 << (i + 1)) - 32'h1);
            applyVec(withExp(dsp(4'(i), 7'(8'h60 + i), 1'b1, 7'(8'h70 + i), 1'b1, 8'h01),
                             full, full, 16'h0000, 5'(i + 1)), 100 + i);
        end
        applyVec(withExp(fr(dsp(4'd5, 7'h11, 1'b0, 7'h22, 1'b1, 8'h01), 4'd5), 16'hFFDF, 16'hFFFF, 16'h0000, 5'd16), 200);
        applyVec(withExp(fr(nop(), 4'd5), 16'hFFDF, 16'hFFDF, 16'h0000, 5'd15), 201);
        applyVec(withExp(br(rstV(), 1'b1, 3'd0), 16'h0000, 16'h0000, 16'h0000, 5'd0), 202);

        // random traffic checked against the reference state
        for (int n = 0; n < 400; n++) begin
            v = nop();
            if (n == 0 || $urandom_range(63) == 0) v.rst = 1'b1;
            v.rv  = 3'($urandom);
            v.rt0 = 7'($urandom_range(7));
            v.rt1 = 7'($urandom_range(7));
            v.rt2 = 7'($urandom_range(7));
            v.fv  = 1'($urandom);
            v.fi  = 4'($urandom);
            v.cv  = ($urandom_range(3) == 0);
            v.cm  = 1'($urandom);
            v.cid = 3'($urandom);
            if ($urandom_range(2) != 0) begin
                v.dv = 1'b1;
                v.di = 4'($urandom);
                if (mValid[v.di] === 1'b1) begin
                    v.fv = 1'b1;
                    v.fi = v.di;
                end
                v.t1 = 7'($urandom_range(7));
                v.t2 = 7'($urandom_range(7));
                v.r1 = ($urandom_range(3) == 0);
                v.r2 = ($urandom_range(3) == 0);
                v.dm = 8'($urandom) & 8'($urandom);
            end
            modelStep(v);
            applyVec(v, 1000 + n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
